// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic execution unit with a valid/ready register pipeline.
// Result and zero flag are formed at entry and carried through STAGES collapsing slices.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = ~(x | y);
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x ^ y);
      3'b110:  r = x & ~y;
      3'b111:  r = x;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [STAGES-1:0] r_zero;
  logic [CNT_W-1:0]  r_count;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_d_res [STAGES];
  logic [STAGES-1:0] w_d_zero;
  logic [WIDTH-1:0]  w_entry_res;
  logic              w_accept;
  logic              w_deliver;

  assign w_entry_res = f_logic_op(op, a, b);

  // Advance chain walked from the output back to the entry stage; the slot past the
  // last stage looks permanently full and drains only when the consumer is ready.
  always_comb begin
    logic w_next_adv;
    logic w_next_v;
    w_adv      = '0;
    w_next_adv = out_ready;
    w_next_v   = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k]   = r_v[k] & (~w_next_v | w_next_adv);
      w_next_adv = w_adv[k];
      w_next_v   = r_v[k];
    end
  end

  assign in_ready  = ~r_v[0] | w_adv[0];
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = r_v[STAGES-1] & out_ready;

  // Per-stage load enables and the payload each stage would capture.
  always_comb begin
    w_load   = '0;
    w_d_zero = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_d_res[k] = '0;
    end
    w_load[0]   = w_accept;
    w_d_res[0]  = w_entry_res;
    w_d_zero[0] = ~|w_entry_res;
    for (int k = 1; k < STAGES; k++) begin
      w_load[k]   = w_adv[k-1];
      w_d_res[k]  = r_res[k-1];
      w_d_zero[k] = r_zero[k-1];
    end
  end

  // Stage valid bits and payload; an empty stage keeps its stale payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_zero <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_res[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k]    <= 1'b1;
          r_res[k]  <= w_d_res[k];
          r_zero[k] <= w_d_zero[k];
        end else if (w_adv[k]) begin
          r_v[k] <= 1'b0;
        end else begin
          r_v[k] <= r_v[k];
        end
      end
    end
  end

  // Delivered-result counter, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_deliver && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign res       = r_res[STAGES-1];
  assign zero      = r_zero[STAGES-1];
  assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and random checks of three logic_unit_pipe configurations
// (32b/2 stages, 8b/1 stage, 8b/4 stages) against a truth-table and queue reference.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        s_in_valid  [3];
  logic        s_out_ready [3];
  logic [2:0]  s_op        [3];
  logic [31:0] s_a         [3];
  logic [31:0] s_b         [3];

  logic        o_in_ready  [3];
  logic        o_out_valid [3];
  logic        o_zero      [3];
  logic [31:0] o_res       [3];
  logic [15:0] o_cnt       [3];

  logic in_ready0, out_valid0, zero0;
  logic in_ready1, out_valid1, zero1;
  logic in_ready2, out_valid2, zero2;
  logic [31:0] res0;
  logic [7:0]  res1, res2;
  logic [15:0] cnt0;
  logic [3:0]  cnt1, cnt2;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[0]), .in_ready(in_ready0),
    .op(s_op[0]), .a(s_a[0]), .b(s_b[0]), .out_valid(out_valid0),
    .out_ready(s_out_ready[0]), .res(res0), .zero(zero0), .op_count(cnt0)
  );
  logic_unit_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[1]), .in_ready(in_ready1),
    .op(s_op[1]), .a(s_a[1][7:0]), .b(s_b[1][7:0]), .out_valid(out_valid1),
    .out_ready(s_out_ready[1]), .res(res1), .zero(zero1), .op_count(cnt1)
  );
  logic_unit_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[2]), .in_ready(in_ready2),
    .op(s_op[2]), .a(s_a[2][7:0]), .b(s_b[2][7:0]), .out_valid(out_valid2),
    .out_ready(s_out_ready[2]), .res(res2), .zero(zero2), .op_count(cnt2)
  );

  always_comb begin
    o_in_ready[0] = in_ready0;  o_out_valid[0] = out_valid0;  o_zero[0] = zero0;
    o_in_ready[1] = in_ready1;  o_out_valid[1] = out_valid1;  o_zero[1] = zero1;
    o_in_ready[2] = in_ready2;  o_out_valid[2] = out_valid2;  o_zero[2] = zero2;
    o_res[0] = res0;
    o_res[1] = {24'h000000, res1};
    o_res[2] = {24'h000000, res2};
    o_cnt[0] = cnt0;
    o_cnt[1] = {12'h000, cnt1};
    o_cnt[2] = {12'h000, cnt2};
  end

  int n_checks = 0;
  int n_err = 0;
  int n_deliv [3];
  logic [32:0] q [$];
  logic last_acc;
  logic [31:0] sweep [8];

  function automatic int st_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  // Reference: per-bit truth table indexed by {a_bit, b_bit}; returns {zero, result}.
  function automatic logic [32:0] ref_op(input int d, input logic [2:0] o,
                                         input logic [31:0] x, input logic [31:0] y);
    logic [3:0]  tt;
    logic [31:0] r;
    int w;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0001;
      3'd3:    tt = 4'b0110;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    w = (d == 0) ? 32 : 8;
    r = 32'h0;
    for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
    return {(r == 32'h0), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of DUT d: entered and left at posedge+1 with inputs already driven.
  task automatic cycle(input int d);
    logic        stalled;
    logic [31:0] held_res;
    logic        held_zero;
    logic [32:0] e;
    int cm;
    #4;
    chk("in_ready", o_in_ready[d],
        ((q.size() == st_of(d)) && !s_out_ready[d]) ? 1'b0 : 1'b1);
    stalled   = o_out_valid[d] & ~s_out_ready[d];
    held_res  = o_res[d];
    held_zero = o_zero[d];
    last_acc  = s_in_valid[d] & o_in_ready[d];
    if (o_out_valid[d]) begin
      chk("out_has_pending", (q.size() > 0), 1'b1);
      if (q.size() > 0) begin
        e = q[0];
        chk("res", o_res[d], e[31:0]);
        chk("zero", o_zero[d], e[32]);
        if (s_out_ready[d]) begin
          void'(q.pop_front());
          n_deliv[d]++;
        end
      end
    end
    if (last_acc) q.push_back(ref_op(d, s_op[d], s_a[d], s_b[d]));
    @(posedge clk);
    #1;
    cm = cmax_of(d);
    chk("op_count", o_cnt[d], (n_deliv[d] > cm) ? cm : n_deliv[d]);
    if (stalled) begin
      chk("hold_valid", o_out_valid[d], 1'b1);
      chk("hold_res", o_res[d], held_res);
      chk("hold_zero", o_zero[d], held_zero);
    end
  endtask

  task automatic send_one(input int d, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
    int lat;
    s_op[d] = o;  s_a[d] = x;  s_b[d] = y;
    s_in_valid[d] = 1'b1;
    s_out_ready[d] = 1'b1;
    cycle(d);
    chk("accepted", last_acc, 1'b1);
    s_in_valid[d] = 1'b0;
    lat = 0;
    while (!o_out_valid[d] && lat < 8) begin
      cycle(d);
      lat++;
    end
    chk("latency", lat, st_of(d) - 1);
  endtask

  task automatic drain(input int d, output int c);
    s_in_valid[d] = 1'b0;
    s_out_ready[d] = 1'b1;
    c = 0;
    while (q.size() > 0 && c < 40) begin
      cycle(d);
      c++;
    end
    chk("drain_empty", q.size(), 0);
    chk("idle_after_drain", o_out_valid[d], 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_out_valid"}, o_out_valid[d], 1'b0);
      chk({tag, "_res"}, o_res[d], 32'h0);
      chk({tag, "_zero"}, o_zero[d], 1'b0);
      chk({tag, "_count"}, o_cnt[d], 16'h0);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    for (int d = 0; d < 3; d++) s_in_valid[d] = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_pulse");
    #2 rst_n = 1'b1;
    q.delete();
    for (int d = 0; d < 3; d++) n_deliv[d] = 0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("ready_after_reset", o_in_ready[d], 1'b1);
  endtask

  initial begin
    int c;
    int nd;
    int acc;
    logic [31:0] m;
    logic [31:0] t1;
    sweep[0] = 32'hF000_F000;  sweep[1] = 32'hFFF0_FFF0;
    sweep[2] = 32'h000F_000F;  sweep[3] = 32'h0FF0_0FF0;
    sweep[4] = 32'h0FFF_0FFF;  sweep[5] = 32'hF00F_F00F;
    sweep[6] = 32'h00F0_00F0;  sweep[7] = 32'hF0F0_F0F0;
    for (int d = 0; d < 3; d++) begin
      s_in_valid[d] = 1'b0;  s_out_ready[d] = 1'b0;
      s_op[d] = 3'b000;  s_a[d] = 32'h0;  s_b[d] = 32'h0;
      n_deliv[d] = 0;
    end
    last_acc = 1'b0;

    #1 rst_n = 1'b0;
    #2 check_reset_state("rst_init");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("ready_first_clock", o_in_ready[d], 1'b1);

    // Directed ops, op sweep and backpressure on every configuration.
    for (int d = 0; d < 3; d++) begin
      m = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      t1 = 32'hFFFF_FF00 & m;
      send_one(d, 3'b010, 32'h0000_00F0, 32'h0000_000F);
      chk("t1_res", o_res[d], t1);
      chk("t1_zero", o_zero[d], (t1 == 32'h0));
      cycle(d);
      chk("t1_count", o_cnt[d], 16'd1);

      send_one(d, 3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      chk("t2_xor_res", o_res[d], 32'h0);
      chk("t2_xor_zero", o_zero[d], 1'b1);
      cycle(d);

      for (int i = 0; i < 8; i++) begin
        send_one(d, 3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("t2_sweep", o_res[d], sweep[i] & m);
        cycle(d);
      end

      s_out_ready[d] = 1'b0;
      for (int i = 0; i < st_of(d); i++) begin
        s_op[d] = 3'($urandom);  s_a[d] = $urandom;  s_b[d] = $urandom;
        s_in_valid[d] = 1'b1;
        cycle(d);
        chk("bp_accept", last_acc, 1'b1);
      end
      s_op[d] = 3'($urandom);  s_a[d] = $urandom;  s_b[d] = $urandom;
      chk("bp_stall_ready", o_in_ready[d], 1'b0);
      cycle(d);
      chk("bp_out_valid", o_out_valid[d], 1'b1);
      nd = n_deliv[d];
      s_out_ready[d] = 1'b1;
      cycle(d);
      chk("bp_late_accept", last_acc, 1'b1);
      drain(d, c);
      chk("bp_delivered", n_deliv[d] - nd, st_of(d) + 1);
    end

    // Streaming at full rate on the 32-bit unit.
    pulse_reset();
    s_out_ready[0] = 1'b1;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      s_op[0] = 3'($urandom);  s_a[0] = $urandom;  s_b[0] = $urandom;
      s_in_valid[0] = 1'b1;
      cycle(0);
      if (last_acc) acc++;
    end
    chk("stream_accepts", acc, 100);
    drain(0, c);
    chk("stream_drain_cycles", c, st_of(0));
    chk("stream_count", o_cnt[0], 16'd100);
    chk("stream_delivered", n_deliv[0], 100);

    // Reset with two operations in flight.
    s_out_ready[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_op[0] = 3'($urandom);  s_a[0] = $urandom;  s_b[0] = $urandom;
      s_in_valid[0] = 1'b1;
      cycle(0);
    end
    s_in_valid[0] = 1'b0;
    chk("midflight_valid", o_out_valid[0], 1'b1);
    pulse_reset();
    s_out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0);
    chk("midflight_nothing_delivered", n_deliv[0], 0);
    chk("midflight_count", o_cnt[0], 16'd0);
    send_one(0, 3'b000, 32'h1234_5678, 32'h0F0F_0F0F);
    cycle(0);
    chk("after_reset_count", o_cnt[0], 16'd1);

    // Random traffic then a full-rate burst on the 8-bit units, saturating op_count.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 60; i++) begin
        s_in_valid[d] = ($urandom_range(0, 3) != 0);
        s_out_ready[d] = ($urandom_range(0, 3) != 0);
        s_op[d] = 3'($urandom);  s_a[d] = $urandom;  s_b[d] = $urandom;
        cycle(d);
      end
      s_out_ready[d] = 1'b1;
      for (int i = 0; i < 20; i++) begin
        s_in_valid[d] = 1'b1;
        s_op[d] = 3'($urandom);  s_a[d] = $urandom;  s_b[d] = $urandom;
        cycle(d);
      end
      drain(d, c);
      chk("sat_enough_delivered", (n_deliv[d] >= 20), 1'b1);
      chk("sat_count", o_cnt[d], 16'd15);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
